decoder_proj_formal_top: RTL and testbench
==========================================

Name: decoder_proj_formal_top

Overview:
- Registered, multi-mode 3-bit decoder driven from the 7-bit project input bus `io_in`.
- Includes a built-in self-check: an invariant-violation flag and a sticky mode-coverage vector, used by the formal/cover flow and the simulation bench.
- Sits at project top level, directly behind the user IO pins. Purely synchronous, single clock domain.

Parameters:
- None. All widths are fixed: input 7, data 8, mode 3.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous and active-low; sampled on rising clk.
- io_in  input  7  [2:0] = addr, [3] = en_n (active-low enable), [6:4] = mode.
- dec_out  output  8  registered decoded word.
- dec_valid  output  1  registered; 1 when dec_out holds an enabled decode.
- dec_parity  output  1  registered XOR-reduce of dec_out.
- modes_seen  output  8  sticky; bit m set once mode m has been decoded with enable active.
- all_modes_seen  output  1  AND-reduce of modes_seen (combinational from the register).
- prop_fail  output  1  sticky invariant-violation flag; must stay 0 in a correct implementation.

Behaviour:
- Reset: when rst_n=0 at a rising edge, all registers clear: dec_out=0x00, dec_valid=0, dec_parity=0, modes_seen=0x00, prop_fail=0. Reset overrides all other activity in that cycle.
- Latency: exactly 1 cycle. The io_in sampled at edge N determines the outputs visible after edge N. There is no input register stage.
- Disable: en_n=1 → dec_out=0x00, dec_valid=0, dec_parity=0; modes_seen unchanged.
- Enable: en_n=0 → dec_valid=1, modes_seen[mode] set, and dec_out per mode (a = addr, 0..7):
  - 000 one-hot: bit a set.
  - 001 active-low one-hot: all bits 1 except bit a.
  - 010 thermometer: bits 0..a set (a=0 → 0x01; a=7 → 0xFF).
  - 011 inverse thermometer: bits a..7 set (a=0 → 0xFF; a=7 → 0x80).
  - 100 binary: {5'b0, a}.
  - 101 gray: {5'b0, a ^ (a>>1)}.
  - 110 reversed one-hot: bit (7-a) set.
  - 111 broadcast: 0xFF regardless of a.
- dec_parity = ^dec_out, computed from the next-state value and registered alongside dec_out.
- Self-check (evaluated on the registered outputs every non-reset cycle); set prop_fail, sticky until reset, if any of:
  - dec_valid=0 and dec_out≠0.
  - dec_valid=1, last mode 000 or 110, and popcount(dec_out)≠1.
  - dec_valid=1, last mode 001, and popcount(dec_out)≠7.
  - dec_parity≠^dec_out.
- The self-check requires registering the previous mode (3 bits).
- No X propagation: every case is fully specified; there is no default latch.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with io_in=0x77 → all outputs 0, prop_fail=0; on release, the next edge decodes normally.
- Broadcast: rst_n=1, io_in=7'b1110111 (mode 7, enabled, addr 7) → after 1 edge: dec_out=0xFF, dec_valid=1, dec_parity=0, modes_seen=0x80.
- Disable: io_in=7'b0001101 (en_n=1) → dec_out=0x00, dec_valid=0, and modes_seen unchanged from its prior value.
- One-hot sweep: mode 000, addr 0..7 → dec_out 0x01,0x02,…,0x80 on consecutive cycles, each with dec_parity=1.
- Mode sweep at addr=3:
  - Expected dec_out for modes 0..7: 0x08, 0xF7, 0x0F, 0xF8, 0x03, 0x02, 0x10, 0xFF.
  - After mode 7: all_modes_seen=1.
  - prop_fail stays 0 throughout.
- Mid-run reset: assert rst_n=0 after the mode sweep → modes_seen, all_modes_seen and dec_out clear on that edge.

Source files
------------

// File: rtl/decoder_proj_formal_top_if.sv
// Pin-side bus of the decoder: the raw project inputs and every registered result.
// The master drives io_in; the slave (the decoder) drives the outputs.
interface decoder_proj_formal_top_if;
    logic [6:0] io_in;
    logic [7:0] dec_out;
    logic       dec_valid;
    logic       dec_parity;
    logic [7:0] modes_seen;
    logic       all_modes_seen;
    logic       prop_fail;

    modport master (
        output io_in,
        input  dec_out, dec_valid, dec_parity, modes_seen, all_modes_seen, prop_fail
    );

    modport slave (
        input  io_in,
        output dec_out, dec_valid, dec_parity, modes_seen, all_modes_seen, prop_fail
    );
endinterface

// File: rtl/decoder_proj_formal_top.sv
// Registered multi-mode 3-bit decoder behind the project IO pins, with a sticky
// mode-coverage vector and a sticky invariant monitor on the registered outputs.
module decoder_proj_formal_top (
    input  logic                        clk,
    input  logic                        rst_n,
    decoder_proj_formal_top_if.slave    bus
);
    localparam logic [2:0] MODE_ONEHOT     = 3'b000;
    localparam logic [2:0] MODE_ONEHOT_N   = 3'b001;
    localparam logic [2:0] MODE_THERM      = 3'b010;
    localparam logic [2:0] MODE_THERM_INV  = 3'b011;
    localparam logic [2:0] MODE_BINARY     = 3'b100;
    localparam logic [2:0] MODE_GRAY       = 3'b101;
    localparam logic [2:0] MODE_ONEHOT_REV = 3'b110;
    localparam logic [2:0] MODE_BROADCAST  = 3'b111;

    logic [2:0] addr;
    logic       en_n;
    logic [2:0] mode;

    assign addr = bus.io_in[2:0];
    assign en_n = bus.io_in[3];
    assign mode = bus.io_in[6:4];

    logic [7:0] onehot_vec;
    logic [7:0] therm_vec;
    logic [7:0] therm_inv_vec;
    logic [7:0] onehot_rev_vec;

    // Per-bit comparisons against addr build every positional pattern in parallel.
    for (genvar gi = 0; gi < 8; gi++) begin : g_bit
        assign onehot_vec[gi]     = (addr == 3'(gi));
        assign therm_vec[gi]      = (3'(gi) <= addr);
        assign therm_inv_vec[gi]  = (3'(gi) >= addr);
        assign onehot_rev_vec[gi] = (addr == 3'(7 - gi));
    end

    logic [7:0] dec_out_next;
    logic       dec_valid_next;
    logic [7:0] modes_seen_next;

    always_comb begin
        dec_out_next    = 8'h00;
        dec_valid_next  = 1'b0;
        modes_seen_next = bus.modes_seen;
        if (!en_n) begin
            dec_valid_next        = 1'b1;
            modes_seen_next[mode] = 1'b1;
            case (mode)
                MODE_ONEHOT:     dec_out_next = onehot_vec;
                MODE_ONEHOT_N:   dec_out_next = ~onehot_vec;
                MODE_THERM:      dec_out_next = therm_vec;
                MODE_THERM_INV:  dec_out_next = therm_inv_vec;
                MODE_BINARY:     dec_out_next = {5'b0, addr};
                MODE_GRAY:       dec_out_next = {5'b0, addr ^ {1'b0, addr[2:1]}};
                MODE_ONEHOT_REV: dec_out_next = onehot_rev_vec;
                MODE_BROADCAST:  dec_out_next = 8'hFF;
                default:         dec_out_next = 8'h00;
            endcase
        end
    end

    logic [7:0] dec_out_reg;
    logic       dec_valid_reg;
    logic       dec_parity_reg;
    logic [7:0] modes_seen_reg;
    logic [2:0] mode_last_reg;
    logic       prop_fail_reg;

    // Invariants are judged on what is currently registered, so the mode that
    // produced dec_out has to be remembered alongside it.
    logic [3:0] pop_count;
    logic       violation;

    always_comb begin
        pop_count = 4'd0;
        for (int i = 0; i < 8; i++) begin
            pop_count = pop_count + {3'b000, dec_out_reg[i]};
        end
        violation = 1'b0;
        if (!dec_valid_reg && (dec_out_reg != 8'h00)) violation = 1'b1;
        if (dec_valid_reg && ((mode_last_reg == MODE_ONEHOT) || (mode_last_reg == MODE_ONEHOT_REV))
            && (pop_count != 4'd1)) violation = 1'b1;
        if (dec_valid_reg && (mode_last_reg == MODE_ONEHOT_N) && (pop_count != 4'd7)) violation = 1'b1;
        if (dec_parity_reg != ^dec_out_reg) violation = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dec_out_reg    <= 8'h00;
            dec_valid_reg  <= 1'b0;
            dec_parity_reg <= 1'b0;
            modes_seen_reg <= 8'h00;
            mode_last_reg  <= 3'b000;
            prop_fail_reg  <= 1'b0;
        end else begin
            dec_out_reg    <= dec_out_next;
            dec_valid_reg  <= dec_valid_next;
            dec_parity_reg <= ^dec_out_next;
            modes_seen_reg <= modes_seen_next;
            mode_last_reg  <= mode;
            prop_fail_reg  <= prop_fail_reg | violation;
        end
    end

    assign bus.dec_out        = dec_out_reg;
    assign bus.dec_valid      = dec_valid_reg;
    assign bus.dec_parity     = dec_parity_reg;
    assign bus.modes_seen     = modes_seen_reg;
    assign bus.all_modes_seen = &modes_seen_reg;
    assign bus.prop_fail      = prop_fail_reg;
endmodule

// File: tb/tb_decoder_proj_formal_top.sv
// Directed, table-driven bench for decoder_proj_formal_top with hand-computed
// expectations, plus reset sequences at start and mid-run.
module tb_decoder_proj_formal_top;
    logic clk;
    logic rst_n;

    decoder_proj_formal_top_if bus ();

    decoder_proj_formal_top dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] io;
        logic [7:0] exp_out;
        logic       exp_valid;
        logic       exp_par;
        logic [7:0] exp_seen;
        logic       exp_all;
    } vec_t;

    vec_t vecs [18];
    int   n_vec;
    int   n_bad;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] out, input logic valid,
                             input logic par, input logic [7:0] seen, input logic all_seen);
        $display("%s io=%h out=%h valid=%b par=%b seen=%h all=%b pf=%b", tag, bus.io_in,
                 bus.dec_out, bus.dec_valid, bus.dec_parity, bus.modes_seen,
                 bus.all_modes_seen, bus.prop_fail);
        check({tag, " dec_out"},        bus.dec_out,                 out);
        check({tag, " dec_valid"},      {7'b0, bus.dec_valid},       {7'b0, valid});
        check({tag, " dec_parity"},     {7'b0, bus.dec_parity},      {7'b0, par});
        check({tag, " modes_seen"},     bus.modes_seen,              seen);
        check({tag, " all_modes_seen"}, {7'b0, bus.all_modes_seen},  {7'b0, all_seen});
        check({tag, " prop_fail"},      {7'b0, bus.prop_fail},       8'h00);
    endtask

    task automatic step(input logic rst_val, input logic [6:0] io);
        @(negedge clk);
        rst_n     = rst_val;
        bus.io_in = io;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.io_in = 7'h77;

        // Broadcast, disable, then one-hot sweep
        vecs[0] = '{7'b1110111, 8'hFF, 1'b1, 1'b0, 8'h80, 1'b0};
        vecs[1] = '{7'b0001101, 8'h00, 1'b0, 1'b0, 8'h80, 1'b0};
        for (int a = 0; a < 8; a++) begin
            vecs[2 + a] = '{7'(a), 8'(1 << a), 1'b1, 1'b1, 8'h81, 1'b0};
        end
        // Mode sweep at addr 3
        vecs[10] = '{{3'd0, 1'b0, 3'd3}, 8'h08, 1'b1, 1'b1, 8'h81, 1'b0};
        vecs[11] = '{{3'd1, 1'b0, 3'd3}, 8'hF7, 1'b1, 1'b1, 8'h83, 1'b0};
        vecs[12] = '{{3'd2, 1'b0, 3'd3}, 8'h0F, 1'b1, 1'b0, 8'h87, 1'b0};
        vecs[13] = '{{3'd3, 1'b0, 3'd3}, 8'hF8, 1'b1, 1'b1, 8'h8F, 1'b0};
        vecs[14] = '{{3'd4, 1'b0, 3'd3}, 8'h03, 1'b1, 1'b0, 8'h9F, 1'b0};
        vecs[15] = '{{3'd5, 1'b0, 3'd3}, 8'h02, 1'b1, 1'b1, 8'hBF, 1'b0};
        vecs[16] = '{{3'd6, 1'b0, 3'd3}, 8'h10, 1'b1, 1'b1, 8'hFF, 1'b1};
        vecs[17] = '{{3'd7, 1'b0, 3'd3}, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1};

        // Reset held two cycles with an enabled broadcast pending on the pins
        step(1'b0, 7'h77);
        check_all("rst1", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 7'h77);
        check_all("rst2", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);

        for (int i = 0; i < 18; i++) begin
            step(1'b1, vecs[i].io);
            check_all($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_valid,
                      vecs[i].exp_par, vecs[i].exp_seen, vecs[i].exp_all);
        end

        // Mid-run reset wins over an enabled decode in the same cycle
        step(1'b0, 7'h77);
        check_all("midrst", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);

        // First edge after release decodes normally; coverage restarts from zero
        step(1'b1, {3'd0, 1'b0, 3'd3});
        check_all("post1", 8'h08, 1'b1, 1'b1, 8'h01, 1'b0);
        step(1'b1, {3'd6, 1'b0, 3'd0});
        check_all("post2", 8'h80, 1'b1, 1'b1, 8'h41, 1'b0);
        step(1'b1, {3'd3, 1'b1, 3'd5});
        check_all("post3", 8'h00, 1'b0, 1'b0, 8'h41, 1'b0);
        step(1'b1, {3'd3, 1'b0, 3'd7});
        check_all("post4", 8'h80, 1'b1, 1'b1, 8'h49, 1'b0);
        step(1'b1, {3'd2, 1'b0, 3'd7});
        check_all("post5", 8'hFF, 1'b1, 1'b0, 8'h4D, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
